// File: rtl/mem_load_resp_pkg.sv
// Shared constants for the memory-stage response unit: lsu_op field layout,
// one-hot size codes, FSM states and the alignment rule.
package mem_load_resp_pkg;

  localparam int ADDR_LSB_W = 3;
  localparam int DATA_W     = 64;

  localparam int OP_EN  = 6;
  localparam int OP_WE  = 5;
  localparam int OP_SZH = 4;
  localparam int OP_SZL = 1;
  localparam int OP_UNS = 0;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Alignment only; a non-one-hot size is not treated as misaligned here.
  function automatic logic isMisaligned(input logic [3:0] size,
                                        input logic [ADDR_LSB_W-1:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return off[1:0] != 2'b00;
      SZ_D:    return off != '0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_resp_load_extend.sv
// Combinational load extraction: selects the addressed bytes from the 64-bit
// read word, sign/zero-extends them and flags misaligned or malformed sizes.
module load_extend
  import mem_load_resp_pkg::*;
(
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic [ADDR_LSB_W-1:0] off_i,
  input  logic [3:0]            size_i,
  input  logic                  uns_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  misalign_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] wordSel;

  assign byteSel = rdata_i[{off_i, 3'b000} +: 8];
  assign halfSel = rdata_i[{off_i[2:1], 4'b0000} +: 16];
  assign wordSel = rdata_i[{off_i[2], 5'b00000} +: 32];

  always_comb begin
    data_o     = '0;
    misalign_o = isMisaligned(size_i, off_i);
    case (size_i)
      SZ_B:    data_o = {{56{~uns_i & byteSel[7]}}, byteSel};
      SZ_H:    data_o = {{48{~uns_i & halfSel[15]}}, halfSel};
      SZ_W:    data_o = {{32{~uns_i & wordSel[31]}}, wordSel};
      SZ_D:    data_o = rdata_i;
      default: misalign_o = 1'b1;
    endcase
    // A flagged access must never leak partial data into the register file.
    if (misalign_o) data_o = '0;
  end

endmodule

// File: rtl/mem_load_resp.sv
// Memory-stage response unit: registers execute results, waits for the SRAM
// read on loads, and presents one write-back beat under valid/ready.
module mem_load_resp
  import mem_load_resp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_lsu_op,
  input  logic [ADDR_LSB_W-1:0] in_addr_lo,
  input  logic [4:0]            in_rd,
  input  logic                  in_rd_we,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  data_sram_rvalid,
  input  logic [DATA_W-1:0]     data_sram_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic                  wb_we,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_misalign,
  output logic                  stray_resp
);

  state_e                state_q, state_d;
  logic [4:0]            rd_q;
  logic                  rdWe_q;
  logic [ADDR_LSB_W-1:0] addrLo_q;
  logic [3:0]            size_q;
  logic                  uns_q;

  logic [4:0]            wbRd_q, wbRd_d;
  logic                  wbWe_q, wbWe_d;
  logic [DATA_W-1:0]     wbData_q, wbData_d;
  logic                  wbMis_q, wbMis_d;
  logic                  stray_q, stray_d;

  logic                  accept;
  logic                  inIsLoad;
  logic                  inIsStore;
  logic [DATA_W-1:0]     extData;
  logic                  extMis;

  assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && wb_ready);
  assign accept    = in_valid && in_ready;
  assign inIsLoad  = in_lsu_op[OP_EN] && !in_lsu_op[OP_WE];
  assign inIsStore = in_lsu_op[OP_EN] && in_lsu_op[OP_WE];

  load_extend u_extend (
    .rdata_i    (data_sram_rdata),
    .off_i      (addrLo_q),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .data_o     (extData),
    .misalign_o (extMis)
  );

  always_comb begin
    state_d  = state_q;
    wbRd_d   = wbRd_q;
    wbWe_d   = wbWe_q;
    wbData_d = wbData_q;
    wbMis_d  = wbMis_q;
    stray_d  = stray_q || (data_sram_rvalid && (state_q != ST_WAIT));

    case (state_q)
      ST_EMPTY: if (accept) state_d = inIsLoad ? ST_WAIT : ST_FULL;
      ST_WAIT: begin
        if (data_sram_rvalid) begin
          state_d  = ST_FULL;
          wbRd_d   = rd_q;
          wbWe_d   = rdWe_q && !extMis;
          wbData_d = extData;
          wbMis_d  = extMis;
        end
      end
      ST_FULL: begin
        if (wb_ready) state_d = accept ? (inIsLoad ? ST_WAIT : ST_FULL) : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    // Non-load results are known at accept, so their beat is built immediately.
    if (accept && !inIsLoad) begin
      wbRd_d   = in_rd;
      wbWe_d   = inIsStore ? 1'b0 : in_rd_we;
      wbData_d = inIsStore ? '0 : in_result;
      wbMis_d  = inIsStore ? isMisaligned(in_lsu_op[OP_SZH:OP_SZL], in_addr_lo) : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wbRd_q   <= '0;
      wbWe_q   <= 1'b0;
      wbData_q <= '0;
      wbMis_q  <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbRd_q   <= wbRd_d;
      wbWe_q   <= wbWe_d;
      wbData_q <= wbData_d;
      wbMis_q  <= wbMis_d;
      stray_q  <= stray_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      rdWe_q   <= 1'b0;
      addrLo_q <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
    end else if (accept) begin
      rd_q     <= in_rd;
      rdWe_q   <= in_rd_we;
      addrLo_q <= in_addr_lo;
      size_q   <= in_lsu_op[OP_SZH:OP_SZL];
      uns_q    <= in_lsu_op[OP_UNS];
    end
  end

  assign wb_valid    = (state_q == ST_FULL);
  assign wb_rd       = wbRd_q;
  assign wb_we       = wbWe_q;
  assign wb_data     = wbData_q;
  assign wb_misalign = wbMis_q;
  assign stray_resp  = stray_q;

endmodule

// File: tb/tb_mem_load_resp.sv
// Directed self-checking bench for mem_load_resp with hand-computed vectors.
module tb_mem_load_resp;

  localparam logic [6:0] OP_LB  = 7'b1000010;
  localparam logic [6:0] OP_LBU = 7'b1000011;
  localparam logic [6:0] OP_LHU = 7'b1000101;
  localparam logic [6:0] OP_LW  = 7'b1001000;
  localparam logic [6:0] OP_BAD = 7'b1000110;
  localparam logic [6:0] OP_SB  = 7'b1100010;
  localparam logic [6:0] OP_ALU = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_lsu_op;
  logic [2:0]  in_addr_lo;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [63:0] in_result;
  logic        data_sram_rvalid;
  logic [63:0] data_sram_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [63:0] wb_data;
  logic        wb_misalign;
  logic        stray_resp;

  int vecCount = 0;
  int errCount = 0;

  mem_load_resp dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_lsu_op        (in_lsu_op),
    .in_addr_lo       (in_addr_lo),
    .in_rd            (in_rd),
    .in_rd_we         (in_rd_we),
    .in_result        (in_result),
    .data_sram_rvalid (data_sram_rvalid),
    .data_sram_rdata  (data_sram_rdata),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_rd            (wb_rd),
    .wb_we            (wb_we),
    .wb_data          (wb_data),
    .wb_misalign      (wb_misalign),
    .stray_resp       (stray_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] off, input logic [4:0] rd,
                         input logic rdWe, input logic [63:0] res);
    in_valid   = 1'b1;
    in_lsu_op  = op;
    in_addr_lo = off;
    in_rd      = rd;
    in_rd_we   = rdWe;
    in_result  = res;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_lsu_op = '0; in_addr_lo = '0; in_rd = '0;
    in_rd_we = 1'b0; in_result = '0; data_sram_rvalid = 1'b0; data_sram_rdata = '0;
    wb_ready = 1'b1;
    tick(); tick();
    vecCount++; if (wb_valid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_valid got %b want 0", wb_valid); end
    vecCount++; if (in_ready !== 1'b1) begin errCount++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
    vecCount++; if ({wb_rd, wb_we, wb_misalign, stray_resp} !== 8'h00) begin errCount++; $display("[TB] FAIL reset_flags got %h want 00", {wb_rd, wb_we, wb_misalign, stray_resp}); end
    vecCount++; if (wb_data !== 64'h0) begin errCount++; $display("[TB] FAIL reset_data got %h want 0", wb_data); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_signed_byte_load();
    present(OP_LB, 3'd3, 5'd5, 1'b1, 64'hDEAD);
    tick();
    in_valid = 1'b0;
    vecCount++; if ({wb_valid, in_ready} !== 2'b00) begin errCount++; $display("[TB] FAIL lb_wait got %b want 00", {wb_valid, in_ready}); end
    tick();
    data_sram_rvalid = 1'b1; data_sram_rdata = 64'h0000_0000_8000_0000;
    vecCount++; if (wb_valid !== 1'b0) begin errCount++; $display("[TB] FAIL lb_early got %b want 0", wb_valid); end
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if (wb_valid !== 1'b1) begin errCount++; $display("[TB] FAIL lb_valid got %b want 1", wb_valid); end
    vecCount++; if (wb_data !== 64'hFFFF_FFFF_FFFF_FF80) begin errCount++; $display("[TB] FAIL lb_data got %h want ffffffffffffff80", wb_data); end
    vecCount++; if ({wb_rd, wb_we, wb_misalign} !== {5'd5, 1'b1, 1'b0}) begin errCount++; $display("[TB] FAIL lb_ctl got %b want 0010110", {wb_rd, wb_we, wb_misalign}); end
    tick();
    vecCount++; if (wb_valid !== 1'b0) begin errCount++; $display("[TB] FAIL lb_drain got %b want 0", wb_valid); end
  endtask

  task automatic test_unsigned_loads();
    present(OP_LHU, 3'd6, 5'd9, 1'b1, 64'h0);
    tick();
    in_valid = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 64'hBEEF_0000_0000_0000;
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if (wb_data !== 64'h0000_0000_0000_BEEF) begin errCount++; $display("[TB] FAIL lhu_data got %h want 000000000000beef", wb_data); end
    vecCount++; if ({wb_valid, wb_we, wb_misalign} !== 3'b110) begin errCount++; $display("[TB] FAIL lhu_ctl got %b want 110", {wb_valid, wb_we, wb_misalign}); end
    present(OP_LBU, 3'd7, 5'd2, 1'b1, 64'h0);
    tick();
    in_valid = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 64'hF3FF_FFFF_FFFF_FFFF;
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if (wb_data !== 64'h0000_0000_0000_00F3) begin errCount++; $display("[TB] FAIL lbu_data got %h want 00000000000000f3", wb_data); end
    tick();
  endtask

  task automatic test_misaligned();
    present(OP_LW, 3'd2, 5'd4, 1'b1, 64'h0);
    tick();
    in_valid = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if ({wb_valid, wb_misalign, wb_we} !== 3'b110) begin errCount++; $display("[TB] FAIL lw_mis_ctl got %b want 110", {wb_valid, wb_misalign, wb_we}); end
    vecCount++; if (wb_data !== 64'h0) begin errCount++; $display("[TB] FAIL lw_mis_data got %h want 0", wb_data); end
    present(OP_BAD, 3'd0, 5'd4, 1'b1, 64'h0);
    tick();
    in_valid = 1'b0; data_sram_rvalid = 1'b1;
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if ({wb_misalign, wb_we, wb_data} !== {1'b1, 1'b0, 64'h0}) begin errCount++; $display("[TB] FAIL badsize got %b_%b_%h want 1_0_0", wb_misalign, wb_we, wb_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    present(OP_ALU, 3'd0, 5'd1, 1'b1, 64'h111);
    tick();
    present(OP_ALU, 3'd0, 5'd2, 1'b1, 64'h222);
    for (int i = 0; i < 3; i++) begin
      vecCount++; if ({wb_valid, in_ready, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd1, 64'h111}) begin errCount++; $display("[TB] FAIL b2b_hold%0d got %b_%b_%0d_%h want 1_0_1_111", i, wb_valid, in_ready, wb_rd, wb_data); end
      tick();
    end
    wb_ready = 1'b1;
    #1;
    vecCount++; if (in_ready !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_ready got %b want 1", in_ready); end
    tick();
    present(OP_ALU, 3'd0, 5'd3, 1'b0, 64'h333);
    vecCount++; if ({wb_valid, wb_rd, wb_we, wb_data} !== {1'b1, 5'd2, 1'b1, 64'h222}) begin errCount++; $display("[TB] FAIL b2b_second got %b_%0d_%b_%h want 1_2_1_222", wb_valid, wb_rd, wb_we, wb_data); end
    tick();
    in_valid = 1'b0;
    vecCount++; if ({wb_valid, wb_rd, wb_we, wb_data} !== {1'b1, 5'd3, 1'b0, 64'h333}) begin errCount++; $display("[TB] FAIL b2b_third got %b_%0d_%b_%h want 1_3_0_333", wb_valid, wb_rd, wb_we, wb_data); end
    tick();
    vecCount++; if (wb_valid !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_drain got %b want 0", wb_valid); end
  endtask

  task automatic test_store_then_load();
    present(OP_SB, 3'd1, 5'd7, 1'b1, 64'hAAAA);
    tick();
    present(OP_LB, 3'd0, 5'd8, 1'b1, 64'h0);
    vecCount++; if ({wb_valid, wb_we, wb_data, in_ready} !== {1'b1, 1'b0, 64'h0, 1'b1}) begin errCount++; $display("[TB] FAIL st_beat got %b_%b_%h_%b want 1_0_0_1", wb_valid, wb_we, wb_data, in_ready); end
    tick();
    in_valid = 1'b0;
    vecCount++; if ({wb_valid, in_ready} !== 2'b00) begin errCount++; $display("[TB] FAIL ld_after_st got %b want 00", {wb_valid, in_ready}); end
    data_sram_rvalid = 1'b1; data_sram_rdata = 64'h0000_0000_0000_007F;
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if ({wb_valid, wb_rd, wb_we, wb_data} !== {1'b1, 5'd8, 1'b1, 64'h7F}) begin errCount++; $display("[TB] FAIL ld_after_st_data got %b_%0d_%b_%h want 1_8_1_7f", wb_valid, wb_rd, wb_we, wb_data); end
    vecCount++; if (stray_resp !== 1'b0) begin errCount++; $display("[TB] FAIL no_stray got %b want 0", stray_resp); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    present(OP_LW, 3'd0, 5'd6, 1'b1, 64'h0);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vecCount++; if ({wb_valid, in_ready, wb_rd, wb_we, wb_misalign, stray_resp} !== {1'b0, 1'b1, 5'd0, 3'b000}) begin errCount++; $display("[TB] FAIL rst_wait got %b want 0100000000", {wb_valid, in_ready, wb_rd, wb_we, wb_misalign, stray_resp}); end
    #2 rst = 1'b0;
    tick();
    data_sram_rvalid = 1'b1; data_sram_rdata = 64'h5555_5555_5555_5555;
    tick();
    data_sram_rvalid = 1'b0;
    vecCount++; if ({stray_resp, wb_valid, in_ready} !== 3'b101) begin errCount++; $display("[TB] FAIL late_rvalid got %b want 101", {stray_resp, wb_valid, in_ready}); end
    vecCount++; if ({wb_data, wb_we} !== 65'h0) begin errCount++; $display("[TB] FAIL late_rvalid_data got %h_%b want 0_0", wb_data, wb_we); end
    tick();
    vecCount++; if ({stray_resp, wb_valid} !== 2'b10) begin errCount++; $display("[TB] FAIL stray_sticky got %b want 10", {stray_resp, wb_valid}); end
  endtask

  initial begin
    test_reset();
    test_signed_byte_load();
    test_unsigned_loads();
    test_misaligned();
    test_back_to_back();
    test_store_then_load();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
